// File: rtl/seg7_pkg.sv
// Shared seven-segment codes and BCD helpers for the DE-board HEX displays.
// Segments are active-low, bit0 = seg a .. bit6 = seg g.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter advanced by a prescaled run tick or a debounced
// step key, with parallel load, wrap reporting and registered HEX readout.
module bcd_counter_display
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50_000_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  step_n,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap_pulse,
    output logic                  wrap_led,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int              PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]        presc;
    logic                 tick;
    logic                 step_sync1;
    logic                 step_sync2;
    logic                 step_prev;
    logic                 step_pulse;
    logic                 advance;

    logic [4*DIGITS-1:0]  inc_val;
    logic [4*DIGITS-1:0]  dec_val;
    logic [4*DIGITS-1:0]  load_clamped;
    logic                 carry;
    logic                 borrow;
    logic                 zero_run;
    logic [DIGITS-1:0]    blank;
    logic [7*DIGITS-1:0]  seg_next;

    assign tick = (presc == PMAX);

    // Free-running only while run is high; freezing keeps the tick phase.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (run) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            step_sync1 <= 1'b1;
            step_sync2 <= 1'b1;
            step_prev  <= 1'b1;
        end else begin
            step_sync1 <= step_n;
            step_sync2 <= step_sync1;
            step_prev  <= step_sync2;
        end
    end

    assign step_pulse = step_prev & ~step_sync2;
    assign advance    = (run & tick) | step_pulse;

    // Ripple BCD increment/decrement; a carry or borrow out of the top digit is the wrap.
    always_comb begin
        inc_val = count;
        dec_val = count;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            wrap_led   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (load) begin
                count    <= load_clamped;
                wrap_led <= 1'b0;
            end else if (advance) begin
                if (up) begin
                    count <= inc_val;
                    if (carry) begin
                        wrap_pulse <= 1'b1;
                        wrap_led   <= 1'b1;
                    end
                end else begin
                    count <= dec_val;
                    if (borrow) begin
                        wrap_pulse <= 1'b1;
                        wrap_led   <= 1'b1;
                    end
                end
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (count[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decoder u_dec (
            .bcd   (count[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_next[7*g +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hex <= '1;
        end else begin
            hex <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed self-checking bench for bcd_counter_display (4 digits, prescale 4, leading-zero blanking).
module tb_bcd_counter_display;

    logic        clock;
    logic        reset;
    logic        run;
    logic        up;
    logic        load;
    logic [15:0] loadValue;
    logic        stepN;
    logic [15:0] count;
    logic        wrapPulse;
    logic        wrapLed;
    logic [27:0] hex;

    int testCount = 0;
    int failCount = 0;
    int pulses;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] SB = 7'b1111111;

    bcd_counter_display #(
        .DIGITS   (4),
        .PRESCALE (4),
        .BLANK_LZ (1)
    ) dut (
        .CLOCK_50   (clock),
        .reset      (reset),
        .run        (run),
        .up         (up),
        .load       (load),
        .load_value (loadValue),
        .step_n     (stepN),
        .count      (count),
        .wrap_pulse (wrapPulse),
        .wrap_led   (wrapLed),
        .hex        (hex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic rn, input logic u);
        load      = ld;
        loadValue = val;
        run       = rn;
        up        = u;
    endtask

    task automatic loadCount(input logic [15:0] val, input logic rn, input logic u);
        applyStimulus(1'b1, val, rn, u);
        @(negedge clock);
        load = 1'b0;
    endtask

    // Holds the key low then high, counting cycles in which wrap_pulse is seen.
    task automatic pressStep(input int lowCycles, input int highCycles, output int seen);
        seen  = 0;
        stepN = 1'b0;
        repeat (lowCycles) begin
            @(negedge clock);
            if (wrapPulse) seen++;
        end
        stepN = 1'b1;
        repeat (highCycles) begin
            @(negedge clock);
            if (wrapPulse) seen++;
        end
    endtask

    initial begin
        reset = 1'b1;
        stepN = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);

        @(negedge clock);
        checkOutput("reset_count", 32'(count), 32'h0000);
        checkOutput("reset_hex", 32'(hex), 32'h0FFF_FFFF);
        checkOutput("reset_wrap_led", 32'(wrapLed), 32'd0);
        checkOutput("reset_wrap_pulse", 32'(wrapPulse), 32'd0);

        // Run for 40 cycles: 10 ticks
        reset = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("run40_count", 32'(count), 32'h0010);
        @(negedge clock);
        checkOutput("run40_hex", 32'(hex), 32'({SB, SB, S1, S0}));

        // Load 9998 and step up twice into a wrap
        loadCount(16'h9998, 1'b0, 1'b1);
        checkOutput("load9998_count", 32'(count), 32'h9998);
        pressStep(3, 4, pulses);
        checkOutput("step1_count", 32'(count), 32'h9999);
        checkOutput("step1_pulses", 32'(pulses), 32'd0);
        checkOutput("step1_wrap_led", 32'(wrapLed), 32'd0);
        pressStep(3, 4, pulses);
        checkOutput("step2_count", 32'(count), 32'h0000);
        checkOutput("step2_pulses", 32'(pulses), 32'd1);
        checkOutput("step2_wrap_led", 32'(wrapLed), 32'd1);
        repeat (5) @(negedge clock);
        checkOutput("wrap_led_sticky", 32'(wrapLed), 32'd1);
        checkOutput("zero_hex", 32'(hex), 32'({SB, SB, SB, S0}));

        // Step down from zero wraps to 9999
        up = 1'b0;
        pressStep(3, 4, pulses);
        checkOutput("down_wrap_count", 32'(count), 32'h9999);
        checkOutput("down_wrap_pulses", 32'(pulses), 32'd1);
        checkOutput("down_wrap_hex", 32'(hex), 32'({S9, S9, S9, S9}));

        // Long press gives a single advance
        pressStep(10, 10, pulses);
        checkOutput("long_press_count", 32'(count), 32'h9998);
        checkOutput("long_press_pulses", 32'(pulses), 32'd0);
        checkOutput("long_press_wrap_led", 32'(wrapLed), 32'd1);

        // Clamped load clears wrap_led
        loadCount(16'h00AF, 1'b0, 1'b0);
        checkOutput("clamp_count", 32'(count), 32'h0099);
        checkOutput("clamp_wrap_led", 32'(wrapLed), 32'd0);
        @(negedge clock);
        checkOutput("clamp_hex", 32'(hex), 32'({SB, SB, S9, S9}));

        // Load versus tick, then tick and step in the same cycle
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        loadCount(16'h0100, 1'b0, 1'b1);
        run = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("pre_tick_count", 32'(count), 32'h0100);
        applyStimulus(1'b1, 16'h0500, 1'b1, 1'b1);
        @(negedge clock);
        load = 1'b0;
        checkOutput("load_beats_tick", 32'(count), 32'h0500);
        @(negedge clock);
        stepN = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("before_tick_step", 32'(count), 32'h0500);
        @(negedge clock);
        checkOutput("tick_and_step", 32'(count), 32'h0501);
        run   = 1'b0;
        stepN = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("tick_and_step_hold", 32'(count), 32'h0501);
        checkOutput("hex_0501", 32'(hex), 32'({SB, S5, S0, S1}));

        // Asynchronous reset mid-count
        loadCount(16'h9999, 1'b0, 1'b1);
        pressStep(3, 4, pulses);
        checkOutput("pre_reset_wrap_led", 32'(wrapLed), 32'd1);
        run = 1'b1;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_count", 32'(count), 32'h0000);
        checkOutput("async_reset_hex", 32'(hex), 32'h0FFF_FFFF);
        checkOutput("async_reset_wrap_led", 32'(wrapLed), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("restart_no_tick", 32'(count), 32'h0000);
        @(negedge clock);
        checkOutput("restart_first_tick", 32'(count), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
